// File: rtl/am_query_arbiter_if.sv
// Bus bundle between the query arbiter, its requesters and the shared AM.
// The master view is the arbiter; the slave view is its environment
// (requesters plus the associative memory).
//
// Valid/ready: a transfer happens on a rising clock edge where both valid and
// ready are high. The sender holds valid and data stable until that edge.
// Once valid is raised, the sender must not drop it before the transfer.
interface am_query_arbiter_if #(
    parameter int NUM_REQ        = 3,
    parameter int HV_DIMENSION   = 2000,
    parameter int LABEL_WIDTH    = 2,
    parameter int DISTANCE_WIDTH = 11
);
    // Requester query side
    logic [NUM_REQ-1:0]              ReqValid_SI;
    logic [NUM_REQ-1:0]              ReqReady_SO;
    logic [NUM_REQ*HV_DIMENSION-1:0] ReqHypervector_DI;
    // Requester response side
    logic [NUM_REQ-1:0]              RspValid_SO;
    logic [NUM_REQ-1:0]              RspReady_SI;
    logic [LABEL_WIDTH-1:0]          RspLabelA_DO;
    logic [LABEL_WIDTH-1:0]          RspLabelV_DO;
    logic [DISTANCE_WIDTH-1:0]       RspDistanceA_DO;
    logic [DISTANCE_WIDTH-1:0]       RspDistanceV_DO;
    // AM query side
    logic                            AmValid_SO;
    logic                            AmReady_SI;
    logic [HV_DIMENSION-1:0]         AmHypervector_DO;
    // AM result side
    logic                            AmResultValid_SI;
    logic                            AmResultReady_SO;
    logic [LABEL_WIDTH-1:0]          AmLabelA_DI;
    logic [LABEL_WIDTH-1:0]          AmLabelV_DI;
    logic [DISTANCE_WIDTH-1:0]       AmDistanceA_DI;
    logic [DISTANCE_WIDTH-1:0]       AmDistanceV_DI;

    modport master (
        input  ReqValid_SI, ReqHypervector_DI, RspReady_SI,
        input  AmReady_SI, AmResultValid_SI,
        input  AmLabelA_DI, AmLabelV_DI, AmDistanceA_DI, AmDistanceV_DI,
        output ReqReady_SO, RspValid_SO,
        output RspLabelA_DO, RspLabelV_DO, RspDistanceA_DO, RspDistanceV_DO,
        output AmValid_SO, AmHypervector_DO, AmResultReady_SO
    );

    modport slave (
        output ReqValid_SI, ReqHypervector_DI, RspReady_SI,
        output AmReady_SI, AmResultValid_SI,
        output AmLabelA_DI, AmLabelV_DI, AmDistanceA_DI, AmDistanceV_DI,
        input  ReqReady_SO, RspValid_SO,
        input  RspLabelA_DO, RspLabelV_DO, RspDistanceA_DO, RspDistanceV_DO,
        input  AmValid_SO, AmHypervector_DO, AmResultReady_SO
    );
endinterface

// File: rtl/am_query_arbiter.sv
// Round-robin arbiter sharing one associative memory between NUM_REQ query
// requesters. One query in flight at a time: IDLE grants and captures the
// query, ISSUE hands it to the AM, WAIT collects the result, RESPOND returns
// it to the requester that issued the query.
module am_query_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int HV_DIMENSION   = 2000,
    parameter int LABEL_WIDTH    = 2,
    parameter int DISTANCE_WIDTH = 11,
    parameter int ID_WIDTH       = 2
) (
    input  logic                 Clk_CI,
    input  logic                 Reset_RI,
    am_query_arbiter_if.master   bus_if,
    output logic [ID_WIDTH-1:0]  GrantId_DO,
    output logic                 Busy_SO,
    output logic [1:0]           State_DO
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [ID_WIDTH-1:0]       ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]       grant_id_q, grant_id_d;
    logic [HV_DIMENSION-1:0]   query_q, query_d;
    logic [LABEL_WIDTH-1:0]    label_a_q, label_a_d, label_v_q, label_v_d;
    logic [DISTANCE_WIDTH-1:0] dist_a_q, dist_a_d, dist_v_q, dist_v_d;

    logic [ID_WIDTH-1:0]       grant;
    logic                      grant_found;
    logic                      rsp_accept;

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && bus_if.ReqValid_SI[idx]) begin
                grant       = ID_WIDTH'(idx);
                grant_found = 1'b1;
            end
        end
    end

    // Only the granted requester's ready can close the response.
    assign rsp_accept = bus_if.RspReady_SI[grant_id_q];

    // State register and datapath registers.
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            query_q    <= '0;
            label_a_q  <= '0;
            label_v_q  <= '0;
            dist_a_q   <= '0;
            dist_v_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            query_q    <= query_d;
            label_a_q  <= label_a_d;
            label_v_q  <= label_v_d;
            dist_a_q   <= dist_a_d;
            dist_v_q   <= dist_v_d;
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        query_d    = query_q;
        label_a_d  = label_a_q;
        label_v_d  = label_v_q;
        dist_a_d   = dist_a_q;
        dist_v_d   = dist_v_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    query_d    = bus_if.ReqHypervector_DI[int'(grant)*HV_DIMENSION +: HV_DIMENSION];
                    grant_id_d = grant;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus_if.AmReady_SI) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_if.AmResultValid_SI) begin
                    label_a_d = bus_if.AmLabelA_DI;
                    label_v_d = bus_if.AmLabelV_DI;
                    dist_a_d  = bus_if.AmDistanceA_DI;
                    dist_v_d  = bus_if.AmDistanceV_DI;
                    state_d   = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (rsp_accept) begin
                    if (grant_id_q == ID_WIDTH'(NUM_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = grant_id_q + 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state; at most one is high.
    always_comb begin
        bus_if.ReqReady_SO      = '0;
        bus_if.RspValid_SO      = '0;
        bus_if.AmValid_SO       = 1'b0;
        bus_if.AmResultReady_SO = 1'b0;
        case (state_q)
            S_IDLE:    if (grant_found) bus_if.ReqReady_SO[grant] = 1'b1;
            S_ISSUE:   bus_if.AmValid_SO = 1'b1;
            S_WAIT:    bus_if.AmResultReady_SO = 1'b1;
            S_RESPOND: bus_if.RspValid_SO[grant_id_q] = 1'b1;
            default:   ;
        endcase
    end

    // Data buses come straight from registers so they hold between transfers.
    assign bus_if.AmHypervector_DO = query_q;
    assign bus_if.RspLabelA_DO     = label_a_q;
    assign bus_if.RspLabelV_DO     = label_v_q;
    assign bus_if.RspDistanceA_DO  = dist_a_q;
    assign bus_if.RspDistanceV_DO  = dist_v_q;
    assign GrantId_DO              = grant_id_q;
    assign Busy_SO                 = (state_q != S_IDLE);
    assign State_DO                = state_q;

endmodule

// File: doc/am_query_arbiter.md
Name: am_query_arbiter

Overview:
- Round-robin scheduler that shares one associative memory (AM) classifier between NUM_REQ query requesters, such as per-window encoders or separate sensor-fusion channels.
- Accepts one query hypervector at a time and drives the AM valid/ready handshake.
- Captures the AM's A/V labels and distances and returns them to the requester that issued the query.
- Sits between the encoder outputs and the AM input/output ports.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
HV_DIMENSION, 2000, query hypervector width
LABEL_WIDTH, 2, AM label width
DISTANCE_WIDTH, 11, AM Hamming distance width
ID_WIDTH, 2, grant index width; must equal ceilLog2(NUM_REQ) (0 not allowed)

Ports:
Clk_CI  in  1  clock
Reset_RI  in  1  reset, synchronous, active-high
ReqValid_SI  in  NUM_REQ  per-requester query valid
ReqReady_SO  out  NUM_REQ  per-requester accept; one-hot or zero
ReqHypervector_DI  in  NUM_REQ*HV_DIMENSION  requester i occupies bits [i*HV_DIMENSION +: HV_DIMENSION]
RspValid_SO  out  NUM_REQ  per-requester result valid; one-hot or zero
RspReady_SI  in  NUM_REQ  per-requester result accept
RspLabelA_DO, RspLabelV_DO  out  LABEL_WIDTH  returned labels (shared bus)
RspDistanceA_DO, RspDistanceV_DO  out  DISTANCE_WIDTH  returned distances (shared bus)
AmValid_SO  out  1  query valid to AM (AM ValidIn)
AmReady_SI  in  1  AM ReadyOut
AmHypervector_DO  out  HV_DIMENSION  query to AM
AmResultValid_SI  in  1  AM ValidOut
AmResultReady_SO  out  1  to AM ReadyIn
AmLabelA_DI, AmLabelV_DI  in  LABEL_WIDTH  AM labels
AmDistanceA_DI, AmDistanceV_DI  in  DISTANCE_WIDTH  AM distances
GrantId_DO  out  ID_WIDTH  index of current or last granted requester
Busy_SO  out  1  high in any state other than IDLE

Behaviour:
- Reset state (Reset_RI high at a clock edge):
  - FSM goes to IDLE; RR pointer = 0.
  - Query, result and GrantId registers clear to 0.
  - All valid/ready outputs are 0 except ReqReady, which follows the IDLE rule below.
- Reset mid-operation aborts the in-flight query with no response. The AM shares this reset.
- FSM state IDLE:
  - Grant = first i with ReqValid_SI[i], searching from pointer upward modulo NUM_REQ.
  - If any request is valid: ReqReady_SO[grant] = 1 combinationally in the same cycle, and the handshake completes that cycle.
  - On that handshake: latch the hypervector slice into the query register, latch GrantId, go to ISSUE.
  - If no request is valid: stay in IDLE with ReqReady = 0.
- FSM state ISSUE:
  - AmValid_SO = 1; AmHypervector_DO = query register, held stable.
  - When AmReady_SI = 1, go to WAIT.
- FSM state WAIT:
  - AmResultReady_SO = 1.
  - When AmResultValid_SI = 1, latch all four AM result fields and go to RESPOND.
- FSM state RESPOND:
  - RspValid_SO[GrantId] = 1; Rsp* buses = latched values, held stable.
  - When RspReady_SI[GrantId] = 1: pointer = (GrantId+1) mod NUM_REQ (wraps from NUM_REQ-1 to 0); go to IDLE.
- RspReady_SI of non-granted requesters is ignored.
- Minimum turnaround is 4 cycles per query plus AM compute time. A new grant is possible in the cycle after the RESPOND handshake.
- Only one query is in flight at a time; there is no pipelining.
- ReqValid_SI is sampled only in IDLE. A requester must hold valid and data until it sees ready.
- Rsp buses and AmHypervector_DO hold their last values outside RESPOND/ISSUE; they do not clear.
- AmValid_SO, AmResultReady_SO, ReqReady_SO and RspValid_SO are never high in the same cycle as each other.

Test Plan:
1. Reset, then req1 valid with HV=0xA..A; AM ready at once; AM returns labelA=2, distA=100, labelV=1, distV=50 after 6 cycles; RspReady1=1 -> ReqReady_SO=3'b010 for one cycle; RspValid_SO=3'b010 carrying those values; pointer becomes 2.
2. All three requests valid continuously, pointer=0 -> grants in order 0,1,2,0; GrantId sequence 0,1,2,0.
3. Pointer=2, only req2 valid, then only req0 valid -> grant 2, pointer wraps to 0, then grant 0.
4. AM holds AmReady_SI=0 for 5 cycles in ISSUE -> AmValid_SO stays 1 and AmHypervector_DO stays stable; ReqReady_SO stays 0 for every requester.
5. In RESPOND with RspReady_SI=3'b101 while GrantId=1, then 3'b010 -> RspValid stays asserted through the first cycle; IDLE is entered only after the second.
6. Reset asserted in WAIT -> next cycle IDLE with Busy_SO=0, pointer=0 and all valids 0; the late AM result is ignored.
